// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and pattern constants for the serial pattern transmitter
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        FIN   = 2'd3
    } state_t;

    // 1001 is the sequence the Mealy detector benches look for.
    localparam logic [3:0] PAT_1001    = 4'b1001;
    localparam logic [3:0] SEQ_DEF_PAT = PAT_1001;

endpackage

// File: rtl/piso_shift.sv
// rtl/piso_shift.sv - parallel-load, MSB-first shift register; MSB is the serial output bit
module piso_shift #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter: repeats a latched pattern MSB-first with zero gaps
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 4,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(SEQ_DEF_PAT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    input  logic [CNT_W-1:0] gap,
    output logic             x_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int              BW       = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BW-1:0]   LAST_IDX = BW'(PAT_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state, state_nxt;
    logic [PAT_W-1:0]   pat_q, pat_nxt, pat_sel;
    logic [PAT_W-1:0]   sreg, load_data;
    logic [CNT_W-1:0]   rep_cnt, rep_nxt;
    logic [CNT_W-1:0]   gap_len, gap_len_nxt;
    logic [CNT_W-1:0]   gap_cnt, gap_cnt_nxt;
    logic [BW-1:0]      bit_cnt, bit_nxt;
    logic               load, shift;
    logic               valid_nxt, busy_nxt, done_nxt;

    assign pat_sel = (pattern == '0) ? DEF_PAT : pattern;

    // The shift register doubles as the x_out flop: it is loaded with zeros
    // whenever the line must idle low (gap, finish, abort).
    piso_shift #(.W(PAT_W)) u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (shift),
        .din   (load_data),
        .q     (sreg)
    );

    assign x_out = sreg[PAT_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pat_q     <= '0;
            rep_cnt   <= '0;
            gap_len   <= '0;
            gap_cnt   <= '0;
            bit_cnt   <= '0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            pat_q     <= pat_nxt;
            rep_cnt   <= rep_nxt;
            gap_len   <= gap_len_nxt;
            gap_cnt   <= gap_cnt_nxt;
            bit_cnt   <= bit_nxt;
            bit_valid <= valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pat_nxt     = pat_q;
        rep_nxt     = rep_cnt;
        gap_len_nxt = gap_len;
        gap_cnt_nxt = gap_cnt;
        bit_nxt     = bit_cnt;
        load        = 1'b0;
        shift       = 1'b0;
        load_data   = '0;
        valid_nxt   = 1'b0;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;

        if (abort) begin
            state_nxt = IDLE;
            load      = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pat_nxt     = pat_sel;
                        rep_nxt     = reps;
                        gap_len_nxt = gap;
                        if (reps == '0) begin
                            state_nxt = FIN;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = SHIFT;
                            load      = 1'b1;
                            load_data = pat_sel;
                            bit_nxt   = LAST_IDX;
                            valid_nxt = 1'b1;
                            busy_nxt  = 1'b1;
                        end
                    end
                end

                SHIFT: begin
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    if (bit_cnt != '0) begin
                        shift   = 1'b1;
                        bit_nxt = bit_cnt - BW'(1);
                    end else begin
                        rep_nxt = rep_cnt - CNT_ONE;
                        load    = 1'b1;
                        if (rep_cnt == CNT_ONE) begin
                            state_nxt = FIN;
                            valid_nxt = 1'b0;
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                        end else if (gap_len != '0) begin
                            state_nxt   = GAP;
                            gap_cnt_nxt = gap_len;
                        end else begin
                            load_data = pat_q;
                            bit_nxt   = LAST_IDX;
                        end
                    end
                end

                GAP: begin
                    // gap_cnt counts the gap bits still owed, including the one on the line now.
                    valid_nxt   = 1'b1;
                    busy_nxt    = 1'b1;
                    gap_cnt_nxt = gap_cnt - CNT_ONE;
                    if (gap_cnt == CNT_ONE) begin
                        state_nxt = SHIFT;
                        load      = 1'b1;
                        load_data = pat_q;
                        bit_nxt   = LAST_IDX;
                    end
                end

                FIN: begin
                    state_nxt = IDLE;
                end

                default: begin
                    state_nxt = IDLE;
                    load      = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - directed self-checking bench for seq_pattern_tx
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] pattern = 4'd0;
    logic [3:0] reps = 4'd0;
    logic [3:0] gap = 4'd0;
    logic       x_out, bit_valid, busy, done;

    int checks = 0;
    int failures = 0;

    logic cap_x [64];
    logic cap_v [64];
    logic cap_b [64];
    logic cap_d [64];

    seq_pattern_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .pattern   (pattern),
        .reps      (reps),
        .gap       (gap),
        .x_out     (x_out),
        .bit_valid (bit_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Returns at the falling edge where the first stream bit is visible.
    task automatic pulse_start(input logic [3:0] p, input logic [3:0] r, input logic [3:0] g);
        @(negedge clk);
        pattern = p;
        reps    = r;
        gap     = g;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            cap_x[i] = x_out;
            cap_v[i] = bit_valid;
            cap_b[i] = busy;
            cap_d[i] = done;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({x_out, bit_valid, busy, done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0000", {x_out, bit_valid, busy, done});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({x_out, bit_valid, busy, done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=0000", {x_out, bit_valid, busy, done});
        end
    endtask

    task automatic test_single();
        logic [3:0] vec;
        logic ex, ev, ed;
        vec = 4'b1001;
        pulse_start(4'b1001, 4'd1, 4'd0);
        capture(8);
        for (int i = 0; i < 8; i++) begin
            ev = (i < 4);
            ex = ev ? vec[3-i] : 1'b0;
            ed = (i == 4);
            checks++;
            if ({cap_x[i], cap_v[i], cap_b[i], cap_d[i]} !== {ex, ev, ev, ed}) begin
                failures++;
                $display("FAIL single[%0d] got=%b exp=%b", i,
                         {cap_x[i], cap_v[i], cap_b[i], cap_d[i]}, {ex, ev, ev, ed});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vec;
        logic [3:0] win;
        logic ex, ev, ed;
        int ycnt;
        int ypos [4];
        vec = 8'b1001_1001;
        pulse_start(4'b1001, 4'd2, 4'd0);
        capture(10);
        for (int i = 0; i < 10; i++) begin
            ev = (i < 8);
            ex = ev ? vec[7-i] : 1'b0;
            ed = (i == 8);
            checks++;
            if ({cap_x[i], cap_v[i], cap_b[i], cap_d[i]} !== {ex, ev, ev, ed}) begin
                failures++;
                $display("FAIL b2b[%0d] got=%b exp=%b", i,
                         {cap_x[i], cap_v[i], cap_b[i], cap_d[i]}, {ex, ev, ev, ed});
            end
        end
        // Overlapping Mealy 1001 detector fed from the captured line.
        win  = 4'b0000;
        ycnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (cap_v[i] === 1'b1) begin
                win = {win[2:0], cap_x[i]};
                if (win == 4'b1001 && ycnt < 4) begin
                    ypos[ycnt] = i;
                    ycnt++;
                end
            end
        end
        checks++;
        if (ycnt != 2) begin
            failures++;
            $display("FAIL b2b_detect_count got=%0d exp=2", ycnt);
        end else begin
            checks++;
            if (ypos[0] != 3 || ypos[1] != 7) begin
                failures++;
                $display("FAIL b2b_detect_pos got=%0d,%0d exp=3,7", ypos[0], ypos[1]);
            end
        end
    endtask

    task automatic test_gap();
        logic [15:0] vec;
        logic ex, ev, ed;
        vec = 16'b1100_0011_0000_1100;
        pulse_start(4'b1100, 4'd3, 4'd2);
        capture(19);
        for (int i = 0; i < 19; i++) begin
            ev = (i < 16);
            ex = ev ? vec[15-i] : 1'b0;
            ed = (i == 16);
            checks++;
            if ({cap_x[i], cap_v[i], cap_b[i], cap_d[i]} !== {ex, ev, ev, ed}) begin
                failures++;
                $display("FAIL gap[%0d] got=%b exp=%b", i,
                         {cap_x[i], cap_v[i], cap_b[i], cap_d[i]}, {ex, ev, ev, ed});
            end
        end
    endtask

    task automatic test_zero_and_default();
        logic [3:0] vec;
        logic ex, ev, ed;
        pulse_start(4'b0110, 4'd0, 4'd3);
        capture(3);
        for (int i = 0; i < 3; i++) begin
            ed = (i == 0);
            checks++;
            if ({cap_x[i], cap_v[i], cap_b[i], cap_d[i]} !== {3'b000, ed}) begin
                failures++;
                $display("FAIL zero_reps[%0d] got=%b exp=%b", i,
                         {cap_x[i], cap_v[i], cap_b[i], cap_d[i]}, {3'b000, ed});
            end
        end
        vec = 4'b1001;
        pulse_start(4'b0000, 4'd1, 4'd0);
        capture(6);
        for (int i = 0; i < 6; i++) begin
            ev = (i < 4);
            ex = ev ? vec[3-i] : 1'b0;
            ed = (i == 4);
            checks++;
            if ({cap_x[i], cap_v[i], cap_b[i], cap_d[i]} !== {ex, ev, ev, ed}) begin
                failures++;
                $display("FAIL default_pat[%0d] got=%b exp=%b", i,
                         {cap_x[i], cap_v[i], cap_b[i], cap_d[i]}, {ex, ev, ev, ed});
            end
        end
    endtask

    task automatic test_ignored_start();
        logic [8:0] vec;
        logic ex, ev, ed;
        vec = 9'b1011_0_1011;
        pulse_start(4'b1011, 4'd2, 4'd1);
        for (int i = 0; i < 12; i++) begin
            cap_x[i] = x_out;
            cap_v[i] = bit_valid;
            cap_b[i] = busy;
            cap_d[i] = done;
            if (i == 1) begin
                start   = 1'b1;
                pattern = 4'b0110;
                reps    = 4'd5;
                gap     = 4'd0;
            end
            if (i == 2) begin
                start   = 1'b0;
                pattern = 4'b1111;
                reps    = 4'd9;
                gap     = 4'd7;
            end
            @(negedge clk);
        end
        for (int i = 0; i < 12; i++) begin
            ev = (i < 9);
            ex = ev ? vec[8-i] : 1'b0;
            ed = (i == 9);
            checks++;
            if ({cap_x[i], cap_v[i], cap_b[i], cap_d[i]} !== {ex, ev, ev, ed}) begin
                failures++;
                $display("FAIL ignored_start[%0d] got=%b exp=%b", i,
                         {cap_x[i], cap_v[i], cap_b[i], cap_d[i]}, {ex, ev, ev, ed});
            end
        end
    endtask

    task automatic test_abort();
        pulse_start(4'b1001, 4'd2, 4'd0);
        @(negedge clk);
        checks++;
        if ({x_out, bit_valid, busy, done} !== 4'b0110) begin
            failures++;
            $display("FAIL abort_bit2 got=%b exp=0110", {x_out, bit_valid, busy, done});
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({x_out, bit_valid, busy, done} !== 4'b0000) begin
            failures++;
            $display("FAIL abort_next got=%b exp=0000", {x_out, bit_valid, busy, done});
        end
        capture(10);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({cap_x[i], cap_v[i], cap_b[i], cap_d[i]} !== 4'b0000) begin
                failures++;
                $display("FAIL abort_quiet[%0d] got=%b exp=0000", i,
                         {cap_x[i], cap_v[i], cap_b[i], cap_d[i]});
            end
        end
        @(negedge clk);
        pattern = 4'b1001;
        reps    = 4'd1;
        gap     = 4'd0;
        start   = 1'b1;
        abort   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        abort   = 1'b0;
        capture(6);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({cap_x[i], cap_v[i], cap_b[i], cap_d[i]} !== 4'b0000) begin
                failures++;
                $display("FAIL abort_over_start[%0d] got=%b exp=0000", i,
                         {cap_x[i], cap_v[i], cap_b[i], cap_d[i]});
            end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] vec;
        logic ex, ev, ed;
        pulse_start(4'b1100, 4'd3, 4'd3);
        repeat (5) @(negedge clk);
        checks++;
        if ({x_out, bit_valid, busy, done} !== 4'b0110) begin
            failures++;
            $display("FAIL rst_mid_gap_pre got=%b exp=0110", {x_out, bit_valid, busy, done});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({x_out, bit_valid, busy, done} !== 4'b0000) begin
            failures++;
            $display("FAIL rst_async_clear got=%b exp=0000", {x_out, bit_valid, busy, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        capture(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({cap_x[i], cap_v[i], cap_b[i], cap_d[i]} !== 4'b0000) begin
                failures++;
                $display("FAIL rst_quiet[%0d] got=%b exp=0000", i,
                         {cap_x[i], cap_v[i], cap_b[i], cap_d[i]});
            end
        end
        vec = 4'b1010;
        pulse_start(4'b1010, 4'd1, 4'd0);
        capture(6);
        for (int i = 0; i < 6; i++) begin
            ev = (i < 4);
            ex = ev ? vec[3-i] : 1'b0;
            ed = (i == 4);
            checks++;
            if ({cap_x[i], cap_v[i], cap_b[i], cap_d[i]} !== {ex, ev, ev, ed}) begin
                failures++;
                $display("FAIL rst_restart[%0d] got=%b exp=%b", i,
                         {cap_x[i], cap_v[i], cap_b[i], cap_d[i]}, {ex, ev, ev, ed});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_zero_and_default();
        test_ignored_start();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
